// File: rtl/dmux16_stream_if.sv
// Handshake bundle for dmux16_stream: one input port, two output ports.
// master = word producer/consumers side, slave = the demux block.
interface dmux16_stream_if;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] a_count;
  logic [15:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] b_count;

  modport master (
    output in_data, in_sel, in_valid,
    input  in_ready,
    input  a_data, a_valid, a_count,
    output a_ready,
    input  b_data, b_valid, b_count,
    output b_ready
  );

  modport slave (
    input  in_data, in_sel, in_valid,
    output in_ready,
    output a_data, a_valid, a_count,
    input  a_ready,
    output b_data, b_valid, b_count,
    input  b_ready
  );
endinterface

// File: rtl/dmux16_stream.sv
// Buffered 1-to-2 demux for 16-bit words, one register stage per output.
// Optional DMUX16_COUNT_EN adds per-output delivered-word counters.
module dmux16_stream (
  input logic            clk,
  input logic            rst_n,
  dmux16_stream_if.slave io
);
  typedef enum logic {EMPTY, FULL} st_t;

  st_t         a_st;
  st_t         b_st;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        a_full;
  logic        b_full;
  logic        rdy;
  logic        acc;
  logic        drn_a;
  logic        drn_b;
  logic        ld_a;
  logic        ld_b;

  assign a_full = (a_st == FULL);
  assign b_full = (b_st == FULL);

  // x_ready feeds in_ready combinationally so a full slot reloads each cycle
  assign rdy   = io.in_sel ? (!b_full | io.b_ready)
                           : (!a_full | io.a_ready);
  assign acc   = io.in_valid & rdy;
  assign drn_a = a_full & io.a_ready;
  assign drn_b = b_full & io.b_ready;
  assign ld_a  = acc & !io.in_sel;
  assign ld_b  = acc & io.in_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_st <= EMPTY;
      b_st <= EMPTY;
      a_q  <= 16'h0000;
      b_q  <= 16'h0000;
    end else begin
      if (ld_a) begin
        a_st <= FULL;
        a_q  <= io.in_data;
      end else if (drn_a) begin
        a_st <= EMPTY;
      end
      if (ld_b) begin
        b_st <= FULL;
        b_q  <= io.in_data;
      end else if (drn_b) begin
        b_st <= EMPTY;
      end
    end
  end

`ifdef DMUX16_COUNT_EN
  logic [15:0] a_cnt;
  logic [15:0] b_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_cnt <= 16'h0000;
      b_cnt <= 16'h0000;
    end else begin
      if (drn_a) a_cnt <= a_cnt + 16'h0001;
      if (drn_b) b_cnt <= b_cnt + 16'h0001;
    end
  end

  assign io.a_count = a_cnt;
  assign io.b_count = b_cnt;
`else
  assign io.a_count = 16'h0000;
  assign io.b_count = 16'h0000;
`endif

  assign io.in_ready = rdy;
  assign io.a_valid  = a_full;
  assign io.b_valid  = b_full;
  assign io.a_data   = a_q;
  assign io.b_data   = b_q;
endmodule
